// File: rtl/rx_buff_pkg.sv
// rtl/rx_buff_pkg.sv - shared state encoding, CAN frame constants and dlc clamp helper
package rx_buff_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_CTRL  = 3'd1,
    RX_DATA  = 3'd2,
    WAIT_END = 3'd3,
    FULL     = 3'd4
  } state_e;

  localparam int HDR_BYTES    = 2;
  localparam int CAN_MAX_DATA = 8;
  localparam int RTR_BIT      = 4;

  // Raw dlc 9..15 still means 8 data bytes on the wire.
  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    return (dlc > 4'(CAN_MAX_DATA)) ? 4'(CAN_MAX_DATA) : dlc;
  endfunction

endpackage

// File: rtl/rx_buff_mem.sv
// rtl/rx_buff_mem.sv - NUM_BYTES x DW register file, one write port, one async read port
module rx_buff_mem #(
  parameter int NUM_BYTES = 10,
  parameter int DW        = 8,
  parameter int AW        = $clog2(NUM_BYTES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BYTES - 1);

  logic [DW-1:0] mem_q [NUM_BYTES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BYTES; i++) mem_q[i] <= '0;
    end else if (wr_en && (wr_addr <= LAST_ADDR)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr <= LAST_ADDR) rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/rx_buff.sv
// rtl/rx_buff.sv - CAN receive frame buffer: captures one good frame and lets the host pop it bytewise
module rx_buff
  import rx_buff_pkg::*;
#(
  parameter int NUM_BYTES = 10,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_data_vld,
  input  logic          rx_frame_end,
  input  logic          rx_frame_ok,
  input  logic          rx_abort,
  input  logic          rx_buff_rd,
  input  logic          rx_buff_rel,
  output logic [DW-1:0] rx_buff_out,
  output logic          rx_buff_full,
  output logic          rx_buff_busy,
  output logic          rx_rd_last,
  output logic          rx_rtr,
  output logic [3:0]    rx_dlc,
  output logic [3:0]    rx_byte_cnt,
  output logic          rx_overrun
);

  localparam int AW = $clog2(NUM_BYTES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  exp_q, exp_d;
  logic        rtr_q, rtr_d;
  logic [3:0]  dlc_q, dlc_d;
  logic        overrun_q, overrun_d;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic        discard;
  logic [3:0]  ctrl_exp;

  assign ctrl_exp = rx_data[RTR_BIT] ? 4'd0 : clamp_dlc(rx_data[3:0]);

  // Abort always discards; frame_end discards unless the frame is complete and good.
  always_comb begin
    discard = 1'b0;
    if (state_q == RX_CTRL || state_q == RX_DATA)
      discard = rx_abort | rx_frame_end;
    else if (state_q == WAIT_END)
      discard = rx_abort | (rx_frame_end & ~rx_frame_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      exp_q     <= '0;
      rtr_q     <= 1'b0;
      dlc_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      exp_q     <= exp_d;
      rtr_q     <= rtr_d;
      dlc_q     <= dlc_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (rx_data_vld) state_d = RX_CTRL;
      RX_CTRL: begin
        if (discard)          state_d = IDLE;
        else if (rx_data_vld) state_d = (ctrl_exp == 4'd0) ? WAIT_END : RX_DATA;
      end
      RX_DATA: begin
        if (discard) state_d = IDLE;
        else if (rx_data_vld && (cnt_q + 4'd1 == 4'(HDR_BYTES) + exp_q)) state_d = WAIT_END;
      end
      WAIT_END: begin
        if (discard)           state_d = IDLE;
        else if (rx_frame_end) state_d = FULL;
      end
      FULL:     if (rx_buff_rel) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    exp_d     = exp_q;
    rtr_d     = rtr_q;
    dlc_d     = dlc_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    wr_addr   = cnt_q;
    if (discard) begin
      cnt_d = '0;
      rtr_d = 1'b0;
      dlc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (rx_data_vld) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          cnt_d   = 4'd1;
        end
        RX_CTRL: if (rx_data_vld) begin
          wr_en = 1'b1;
          cnt_d = 4'(HDR_BYTES);
          rtr_d = rx_data[RTR_BIT];
          dlc_d = rx_data[3:0];
          exp_d = ctrl_exp;
        end
        RX_DATA: if (rx_data_vld) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 4'd1;
        end
        WAIT_END: if (rx_frame_end) rd_ptr_d = '0;
        FULL: begin
          if (rx_buff_rel) begin
            cnt_d    = '0;
            rtr_d    = 1'b0;
            dlc_d    = '0;
            rd_ptr_d = '0;
          end else if (rx_buff_rd && (rd_ptr_q != cnt_q - 4'd1)) begin
            rd_ptr_d = rd_ptr_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
    // A dropped byte in the same cycle as a release keeps the overrun visible.
    if (rx_buff_rel && !rx_data_vld)       overrun_d = 1'b0;
    if (state_q == FULL && rx_data_vld)    overrun_d = 1'b1;
  end

  rx_buff_mem #(
    .NUM_BYTES (NUM_BYTES),
    .DW        (DW),
    .AW        (AW)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rx_buff_out)
  );

  always_comb begin
    rx_buff_full = (state_q == FULL);
    rx_buff_busy = (state_q == RX_CTRL) || (state_q == RX_DATA) || (state_q == WAIT_END);
    rx_rd_last   = rx_buff_full && (rd_ptr_q == cnt_q - 4'd1);
    rx_rtr       = rtr_q;
    rx_dlc       = dlc_q;
    rx_byte_cnt  = cnt_q;
    rx_overrun   = overrun_q;
  end

endmodule

// File: tb/tb_rx_buff.sv
// tb/tb_rx_buff.sv - scoreboard bench for rx_buff: directed scenarios plus random frames
module tb_rx_buff;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_data_vld = 1'b0;
  logic       rx_frame_end = 1'b0;
  logic       rx_frame_ok = 1'b0;
  logic       rx_abort = 1'b0;
  logic       rx_buff_rd;
  logic       rx_buff_rel;
  logic [7:0] rx_buff_out;
  logic       rx_buff_full, rx_buff_busy, rx_rd_last, rx_rtr, rx_overrun;
  logic [3:0] rx_dlc, rx_byte_cnt;

  logic mon_rd = 1'b0, mon_rel = 1'b0, drv_rel = 1'b0;
  logic mon_en = 1'b1;
  assign rx_buff_rd  = mon_rd;
  assign rx_buff_rel = mon_rel | drv_rel;

  always #5 clk = ~clk;

  rx_buff dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_data_vld(rx_data_vld),
    .rx_frame_end(rx_frame_end), .rx_frame_ok(rx_frame_ok), .rx_abort(rx_abort),
    .rx_buff_rd(rx_buff_rd), .rx_buff_rel(rx_buff_rel), .rx_buff_out(rx_buff_out),
    .rx_buff_full(rx_buff_full), .rx_buff_busy(rx_buff_busy), .rx_rd_last(rx_rd_last),
    .rx_rtr(rx_rtr), .rx_dlc(rx_dlc), .rx_byte_cnt(rx_byte_cnt), .rx_overrun(rx_overrun)
  );

  typedef struct packed {
    logic [9:0][7:0] b;
    logic [3:0]      n;
    logic            rtr;
    logic [3:0]      dlc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         consumed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [20:0] all_outs();
    return {rx_buff_full, rx_buff_busy, rx_rd_last, rx_rtr, rx_dlc, rx_byte_cnt, rx_overrun, rx_buff_out};
  endfunction

  // Reference: a frame holds 2 header bytes plus min(dlc,8) data bytes (none for rtr).
  function automatic int frame_len(input logic [7:0] ctrl);
    int d;
    d = ctrl[4] ? 0 : ((ctrl[3:0] > 8) ? 8 : int'(ctrl[3:0]));
    return 2 + d;
  endfunction

  task automatic push_expected();
    exp_t e;
    int   n;
    e = '0;
    n = frame_len(tx_q[1]);
    for (int i = 0; i < n; i++) e.b[i] = tx_q[i];
    e.n   = 4'(n);
    e.rtr = tx_q[1][4];
    e.dlc = tx_q[1][3:0];
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_data_vld = 1'b1;
    @(posedge clk); #1;
    rx_data_vld = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_all(input int max_gap);
    foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, max_gap));
  endtask

  task automatic chk_idle(input string name);
    chk(name, {rx_buff_full, rx_buff_busy, rx_byte_cnt, rx_rtr, rx_dlc}, 0);
  endtask

  task automatic send_end(input logic ok, input logic exp_full);
    rx_frame_end = 1'b1;
    rx_frame_ok  = ok;
    @(negedge clk);
    chk("full_before_end", rx_buff_full, 0);
    @(posedge clk); #1;
    rx_frame_end = 1'b0;
    rx_frame_ok  = 1'b0;
    @(negedge clk);
    chk("full_after_end", rx_buff_full, exp_full);
    if (!exp_full) chk_idle("discard_ok0_or_short");
    @(posedge clk); #1;
  endtask

  task automatic send_abort();
    rx_abort = 1'b1;
    @(posedge clk); #1;
    rx_abort = 1'b0;
    @(negedge clk);
    chk_idle("discard_abort");
    @(posedge clk); #1;
  endtask

  task automatic wait_consumed(input int target);
    int t = 0;
    while (consumed < target && t < 300) begin @(posedge clk); t++; end
    #1;
    chk("consume_timeout", consumed >= target, 1);
  endtask

  task automatic good_frame();
    push_expected();
    send_all(2);
    send_end(1'b1, 1'b1);
    wait_consumed(consumed + 1);
  endtask

  // Monitor: pops one expected frame whenever the DUT shows full, reads it out and releases it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n && rx_buff_full) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_full", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("hdr_rtr", rx_rtr, e.rtr);
          chk("hdr_dlc", rx_dlc, e.dlc);
          chk("hdr_cnt", rx_byte_cnt, e.n);
          for (int i = 0; i < int'(e.n); i++) begin
            chk("rd_byte", rx_buff_out, e.b[i]);
            chk("rd_last", rx_rd_last, (i == int'(e.n) - 1));
            mon_rd = 1'b1;
            @(negedge clk);
            mon_rd = 1'b0;
          end
          chk("rd_saturate", rx_buff_out, e.b[e.n - 1]);
          chk("rd_last_sat", rx_rd_last, 1);
        end
        mon_rel = 1'b1;
        @(negedge clk);
        mon_rel = 1'b0;
        chk("release", {rx_buff_full, rx_byte_cnt, rx_rtr, rx_dlc}, 0);
        consumed++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    int kind, n, k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", all_outs(), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of the data phase
    tx_q = '{8'hA5, 8'h08, 8'h01, 8'h02, 8'h03};
    send_all(0);
    chk("busy_mid_frame", rx_buff_busy, 1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", all_outs(), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    tx_q = '{8'hA5, 8'h28, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    good_frame();
    tx_q = '{8'h12, 8'h13, 8'hEE};
    good_frame();
    tx_q = '{8'h40, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    good_frame();
    tx_q = '{8'h21, 8'h00};
    good_frame();

    tx_q = '{8'h01, 8'h08, 8'h10, 8'h20, 8'h30};
    send_all(1);
    send_abort();
    tx_q = '{8'h02, 8'h02, 8'h99, 8'h98};
    send_all(1);
    send_end(1'b0, 1'b0);
    tx_q = '{8'h03, 8'h05, 8'h01};
    send_all(1);
    send_end(1'b1, 1'b0);

    // Overrun while full, host side driven directly
    mon_en = 1'b0;
    tx_q = '{8'h3C, 8'h02, 8'h77, 8'h88};
    send_all(0);
    send_end(1'b1, 1'b1);
    held = rx_buff_out;
    chk("full_out_first", held, 8'h3C);
    send_byte(8'h55, 0);
    @(negedge clk);
    chk("overrun_set", {rx_overrun, rx_buff_full, rx_byte_cnt}, {1'b1, 1'b1, 4'd4});
    chk("overrun_out_same", rx_buff_out, held);
    @(posedge clk); #1;
    drv_rel = 1'b1;
    send_byte(8'h56, 0);
    drv_rel = 1'b0;
    @(negedge clk);
    chk("rel_vld_overrun", {rx_overrun, rx_buff_full, rx_byte_cnt}, {1'b1, 1'b0, 4'd0});
    @(posedge clk); #1;
    tx_q = '{8'h3D, 8'h01, 8'h42};
    send_all(0);
    send_end(1'b1, 1'b1);
    chk("overrun_sticky", rx_overrun, 1);
    drv_rel = 1'b1;
    @(posedge clk); #1;
    drv_rel = 1'b0;
    @(negedge clk);
    chk("rel_clears_overrun", {rx_overrun, rx_buff_full}, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    for (int f = 0; f < 40; f++) begin
      tx_q.delete();
      tx_q.push_back(8'($urandom));
      tx_q.push_back(8'($urandom));
      n = frame_len(tx_q[1]);
      kind = $urandom_range(0, 5);
      if (kind == 2 && n == 2) kind = 3;
      k = (kind == 2) ? $urandom_range(2, n - 1) : n + ((kind >= 3) ? $urandom_range(0, 2) : 0);
      while (tx_q.size() < k) tx_q.push_back(8'($urandom));
      if (kind == 0) begin
        while (tx_q.size() > 1 + $urandom_range(0, n)) void'(tx_q.pop_back());
        send_all(2);
        send_abort();
      end else if (kind == 1) begin
        send_all(2);
        send_end(1'b0, 1'b0);
      end else if (kind == 2) begin
        send_all(2);
        send_end(1'b1, 1'b0);
      end else begin
        good_frame();
      end
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
